vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Generates 640x480@60 VGA raster timing from vga_clk (25.175 MHz): h_cnt/v_cnt, hsync/vsync, active.
//  Drives every layer renderer (background, sprites) and the VGA connector.
//  Each renderer maps h_cnt/v_cnt to ROM addresses and gates colour with active.
//  Also emits line/frame strobes and active-area pixel coordinates for game logic.
// PARAMETERS
//  H_SYNC_PULSE    96   hsync pulse width, pixels
//  H_BACK_PORCH    48   horizontal back porch, pixels
//  H_ACTIVE_TIME   640  visible pixels per line
//  H_FRONT_PORCH   16   horizontal front porch, pixels
//  H_LINE_PERIOD   800  total pixels per line; must equal sum of the four above
//  V_SYNC_PULSE    2    vsync pulse width, lines
//  V_BACK_PORCH    33   vertical back porch, lines
//  V_ACTIVE_TIME   480  visible lines
//  V_FRONT_PORCH   10   vertical front porch, lines
//  V_FRAME_PERIOD  525  total lines per frame; must equal sum of the four above
// PORTS
//  vga_clk      in   1   pixel clock
//  rst_n        in   1   asynchronous reset, active low
//  ena          in   1   count enable; low = all state and outputs hold
//  h_cnt        out  12  horizontal position, 0..H_LINE_PERIOD-1
//  v_cnt        out  12  vertical position, 0..V_FRAME_PERIOD-1
//  hsync        out  1   horizontal sync, active low
//  vsync        out  1   vertical sync, active low
//  active       out  1   high inside the visible window
//  px_x         out  10  visible column 0..639 while active, else 0
//  px_y         out  9   visible row 0..479 while active, else 0
//  line_start   out  1   1-cycle strobe when h_cnt wraps to 0
//  frame_start  out  1   1-cycle strobe when (h_cnt,v_cnt) wraps to (0,0)
//  frame_cnt    out  16  frames completed; present only with VGA_FRAME_CNT_EN
// BEHAVIOUR
//  - Reset values (async on rst_n low): h_cnt=0, v_cnt=0, hsync=0, vsync=0, active=0, px_x=0, px_y=0.
//    line_start=0, frame_start=0, frame_cnt=0. First cycle after release shows (1,0).
//  - All outputs are registered.
//  - Outputs are computed from next-count values, so every output matches the h_cnt/v_cnt of the same cycle.
//  - h_cnt increments by 1 per ena cycle. At H_LINE_PERIOD-1 it wraps to 0.
//  - v_cnt increments only on h_cnt wrap. At V_FRAME_PERIOD-1 it wraps to 0 together with h_cnt.
//  - hsync=0 when h_cnt<H_SYNC_PULSE, else 1.
//  - vsync=0 when v_cnt<V_SYNC_PULSE, else 1.
//  - Horizontal window: HS=H_SYNC_PULSE+H_BACK_PORCH (144). Visible when HS <= h_cnt <= HS+H_ACTIVE_TIME-1 (783).
//  - Vertical window: VS=V_SYNC_PULSE+V_BACK_PORCH (35). Visible when VS <= v_cnt <= VS+V_ACTIVE_TIME-1 (514).
//  - active=1 only when both windows hold.
//  - While active: px_x=h_cnt-HS and px_y=v_cnt-VS, truncated to port width. Both are 0 when not active.
//  - line_start=1 for exactly the cycle h_cnt==0 reached by wrap. Never asserted out of reset.
//  - frame_start=1 for exactly the cycle both counters reached 0 by wrap. It coincides with line_start.
//  - ena low: counters, syncs, px_* and frame_cnt hold; line_start and frame_start forced 0.
//    On ena high, counting resumes from the held position; no strobe is repeated.
//  - rst_n asserted mid-line or mid-frame: immediate return to reset values, no partial strobe.
// CONFIGURATION
//  - VGA_FRAME_CNT_EN defined: frame_cnt port exists. It increments modulo 2^16 on each frame_start.
//  - Not defined: port and register are absent; all other behaviour is identical.
// STRUCTURE
//  - Package vga_timing_pkg: the ten timing constants, derived HS/VS/H_END/V_END, and the 12-bit count width.
//  - Sub-module vga_axis_cnt: wrap counter with period, enable and tick-in inputs.
//    Provides wrap-out and a sync/window compare. Instantiated once for h and once for v.
//    The h wrap-out drives the v tick-in.
// TESTING
//  1. Reset release, ena=1, 800 cycles -> h_cnt 0..799 then 0; line_start high only on the wrap cycle; v_cnt=1.
//  2. hsync low for h_cnt 0..95, high for 96..799; vsync low for v_cnt 0..1 only.
//     Measured periods: 800 and 420000 cycles.
//  3. At v_cnt=35: h_cnt=143 gives active=0; 144 gives active=1, px_x=0, px_y=0.
//     783 gives px_x=639; 784 gives active=0. At v_cnt=514, px_y=479; at 515, active=0 all line.
//  4. Run to v_cnt=524, h_cnt=799 -> next cycle is (0,0) with frame_start=1 and line_start=1.
//     With VGA_FRAME_CNT_EN, frame_cnt goes 0->1.
//  5. Drop ena for 10 cycles at h_cnt=500 -> h_cnt stays 500, strobes 0; raise ena -> 501 next cycle.
//  6. Pulse rst_n low at (v=200,h=300) -> all outputs at reset values the same cycle.
//     After release, counting restarts and the next frame_start comes 420000 cycles later.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared constants and types for the 640x480@60 VGA raster generator.
//   Holds the ten default timing constants, the derived visible-window edges,
//   the counter width and the pixel-coordinate widths.
//   Imported by vga_axis_cnt and vga_timing_gen.
// ----------------------------------------------------------------------------
package vga_timing_pkg;

   // Horizontal timing, in pixel clocks
   localparam int H_SYNC_PULSE   = 96;
   localparam int H_BACK_PORCH   = 48;
   localparam int H_ACTIVE_TIME  = 640;
   localparam int H_FRONT_PORCH  = 16;
   localparam int H_LINE_PERIOD  = 800;

   // Vertical timing, in lines
   localparam int V_SYNC_PULSE   = 2;
   localparam int V_BACK_PORCH   = 33;
   localparam int V_ACTIVE_TIME  = 480;
   localparam int V_FRONT_PORCH  = 10;
   localparam int V_FRAME_PERIOD = 525;

   // First and last visible positions on each axis
   localparam int HS    = H_SYNC_PULSE + H_BACK_PORCH;
   localparam int VS    = V_SYNC_PULSE + V_BACK_PORCH;
   localparam int H_END = HS + H_ACTIVE_TIME - 1;
   localparam int V_END = VS + V_ACTIVE_TIME - 1;

   // Port widths
   localparam int CNT_W       = 12;
   localparam int PX_X_W      = 10;
   localparam int PX_Y_W      = 9;
   localparam int FRAME_CNT_W = 16;

   typedef logic [CNT_W-1:0]       cnt_t;
   typedef logic [PX_X_W-1:0]      px_x_t;
   typedef logic [PX_Y_W-1:0]      px_y_t;
   typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

   // True when the four segments of an axis add up to its period
   function automatic bit axis_consistent(input int sync_len, input int back,
                                          input int act, input int front,
                                          input int period);
      return (sync_len + back + act + front) == period;
   endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// ----------------------------------------------------------------------------
// vga_axis_cnt
//   One raster axis: a modulo-PERIOD counter that advances on (ena_i & tick_i)
//   plus the sync and visible-window decodes for that axis.
//   The horizontal instance ticks every pixel; the vertical instance ticks on
//   the horizontal wrap.
//
// Ports
//   clk_i       in   1      pixel clock
//   rst_ni      in   1      asynchronous reset, active low
//   ena_i       in   1      global count enable
//   tick_i      in   1      advance request for this axis
//   cnt_o       out  CNT_W  registered count
//   cnt_next_o  out  CNT_W  count value that will be loaded at the next edge
//   wrap_o      out  1      this edge takes the count from PERIOD-1 to 0
//   sync_o      out  1      registered sync, low while count < SYNC_LEN
//   win_next_o  out  1      next count lies in [WIN_START, WIN_END]
// ----------------------------------------------------------------------------
module vga_axis_cnt
   import vga_timing_pkg::*;
#(
   parameter int PERIOD    = H_LINE_PERIOD,
   parameter int SYNC_LEN  = H_SYNC_PULSE,
   parameter int WIN_START = HS,
   parameter int WIN_END   = H_END
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic ena_i,
   input  logic tick_i,
   output cnt_t cnt_o,
   output cnt_t cnt_next_o,
   output logic wrap_o,
   output logic sync_o,
   output logic win_next_o
);

   localparam cnt_t LAST_C   = cnt_t'(PERIOD - 1);
   localparam cnt_t SYNC_C   = cnt_t'(SYNC_LEN);
   localparam cnt_t WIN_LO_C = cnt_t'(WIN_START);
   localparam cnt_t WIN_HI_C = cnt_t'(WIN_END);

   cnt_t cnt_q;
   cnt_t cnt_d;
   logic sync_q;
   logic sync_d;

   always_comb begin
      cnt_d  = cnt_q;
      wrap_o = 1'b0;
      if (ena_i && tick_i) begin
         if (cnt_q == LAST_C) begin
            cnt_d  = '0;
            wrap_o = 1'b1;
         end else begin
            cnt_d  = cnt_q + cnt_t'(1);
         end
      end
   end

   // Decodes use the next count so they line up with the count they describe
   assign sync_d     = (cnt_d >= SYNC_C);
   assign win_next_o = (cnt_d >= WIN_LO_C) && (cnt_d <= WIN_HI_C);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         sync_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sync_q <= sync_d;
      end
   end

   assign cnt_o      = cnt_q;
   assign cnt_next_o = cnt_d;
   assign sync_o     = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//   640x480@60 VGA raster timing from the 25.175 MHz pixel clock.
//   Every output is registered and describes the same raster position as
//   h_cnt/v_cnt in that cycle.
//
// Ports
//   vga_clk      in   1   pixel clock
//   rst_n        in   1   asynchronous reset, active low
//   ena          in   1   count enable; low holds all state, strobes forced 0
//   h_cnt        out  12  horizontal position 0..H_LINE_PERIOD-1
//   v_cnt        out  12  vertical position 0..V_FRAME_PERIOD-1
//   hsync        out  1   horizontal sync, active low
//   vsync        out  1   vertical sync, active low
//   active       out  1   inside the visible window
//   px_x         out  10  visible column while active, else 0
//   px_y         out  9   visible row while active, else 0
//   frame_cnt    out  16  frames completed (only with VGA_FRAME_CNT_EN)
//   line_start   out  1   one-cycle strobe when h_cnt wraps to 0
//   frame_start  out  1   one-cycle strobe when both counters wrap to 0
//
// Build option
//   VGA_FRAME_CNT_EN : adds the frame_cnt port and its 16-bit counter.
// ----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int H_SYNC_PULSE   = vga_timing_pkg::H_SYNC_PULSE,
   parameter int H_BACK_PORCH   = vga_timing_pkg::H_BACK_PORCH,
   parameter int H_ACTIVE_TIME  = vga_timing_pkg::H_ACTIVE_TIME,
   parameter int H_FRONT_PORCH  = vga_timing_pkg::H_FRONT_PORCH,
   parameter int H_LINE_PERIOD  = vga_timing_pkg::H_LINE_PERIOD,
   parameter int V_SYNC_PULSE   = vga_timing_pkg::V_SYNC_PULSE,
   parameter int V_BACK_PORCH   = vga_timing_pkg::V_BACK_PORCH,
   parameter int V_ACTIVE_TIME  = vga_timing_pkg::V_ACTIVE_TIME,
   parameter int V_FRONT_PORCH  = vga_timing_pkg::V_FRONT_PORCH,
   parameter int V_FRAME_PERIOD = vga_timing_pkg::V_FRAME_PERIOD
) (
   input  logic                                     vga_clk,
   input  logic                                     rst_n,
   input  logic                                     ena,
   output logic [vga_timing_pkg::CNT_W-1:0]         h_cnt,
   output logic [vga_timing_pkg::CNT_W-1:0]         v_cnt,
   output logic                                     hsync,
   output logic                                     vsync,
   output logic                                     active,
   output logic [vga_timing_pkg::PX_X_W-1:0]        px_x,
   output logic [vga_timing_pkg::PX_Y_W-1:0]        px_y,
`ifdef VGA_FRAME_CNT_EN
   output logic [vga_timing_pkg::FRAME_CNT_W-1:0]   frame_cnt,
`endif
   output logic                                     line_start,
   output logic                                     frame_start
);

   import vga_timing_pkg::*;

   localparam int H_WIN_LO = H_SYNC_PULSE + H_BACK_PORCH;
   localparam int H_WIN_HI = H_WIN_LO + H_ACTIVE_TIME - 1;
   localparam int V_WIN_LO = V_SYNC_PULSE + V_BACK_PORCH;
   localparam int V_WIN_HI = V_WIN_LO + V_ACTIVE_TIME - 1;

   // A period that disagrees with its segments would shift the visible window
   if (!axis_consistent(H_SYNC_PULSE, H_BACK_PORCH, H_ACTIVE_TIME,
                        H_FRONT_PORCH, H_LINE_PERIOD)) begin : g_bad_h
      $error("vga_timing_gen: horizontal segments do not sum to H_LINE_PERIOD");
   end
   if (!axis_consistent(V_SYNC_PULSE, V_BACK_PORCH, V_ACTIVE_TIME,
                        V_FRONT_PORCH, V_FRAME_PERIOD)) begin : g_bad_v
      $error("vga_timing_gen: vertical segments do not sum to V_FRAME_PERIOD");
   end

   cnt_t  h_next;
   cnt_t  v_next;
   logic  h_wrap;
   logic  v_wrap;
   logic  h_win_next;
   logic  v_win_next;

   logic  active_d;
   logic  active_q;
   px_x_t px_x_d;
   px_x_t px_x_q;
   px_y_t px_y_d;
   px_y_t px_y_q;
   logic  line_start_d;
   logic  line_start_q;
   logic  frame_start_d;
   logic  frame_start_q;

   vga_axis_cnt #(
      .PERIOD    (H_LINE_PERIOD),
      .SYNC_LEN  (H_SYNC_PULSE),
      .WIN_START (H_WIN_LO),
      .WIN_END   (H_WIN_HI)
   ) u_h_axis (
      .clk_i      (vga_clk),
      .rst_ni     (rst_n),
      .ena_i      (ena),
      .tick_i     (1'b1),
      .cnt_o      (h_cnt),
      .cnt_next_o (h_next),
      .wrap_o     (h_wrap),
      .sync_o     (hsync),
      .win_next_o (h_win_next)
   );

   // The vertical axis only moves when the line wraps, so its wrap-out is
   // exactly the frame wrap.
   vga_axis_cnt #(
      .PERIOD    (V_FRAME_PERIOD),
      .SYNC_LEN  (V_SYNC_PULSE),
      .WIN_START (V_WIN_LO),
      .WIN_END   (V_WIN_HI)
   ) u_v_axis (
      .clk_i      (vga_clk),
      .rst_ni     (rst_n),
      .ena_i      (ena),
      .tick_i     (h_wrap),
      .cnt_o      (v_cnt),
      .cnt_next_o (v_next),
      .wrap_o     (v_wrap),
      .sync_o     (vsync),
      .win_next_o (v_win_next)
   );

   // Strobes derive from the wraps, which already require ena, so they drop
   // to 0 while paused and cannot repeat on resume.
   always_comb begin
      active_d      = h_win_next & v_win_next;
      px_x_d        = '0;
      px_y_d        = '0;
      if (active_d) begin
         px_x_d = px_x_t'(h_next - cnt_t'(H_WIN_LO));
         px_y_d = px_y_t'(v_next - cnt_t'(V_WIN_LO));
      end
      line_start_d  = h_wrap;
      frame_start_d = v_wrap;
   end

   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q      <= 1'b0;
         px_x_q        <= '0;
         px_y_q        <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         active_q      <= active_d;
         px_x_q        <= px_x_d;
         px_y_q        <= px_y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   frame_cnt_t frame_cnt_q;
   frame_cnt_t frame_cnt_d;

   // Wraps naturally modulo 2^16
   assign frame_cnt_d = frame_start_d ? frame_cnt_q + frame_cnt_t'(1) : frame_cnt_q;

   always_ff @(posedge vga_clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

   assign active      = active_q;
   assign px_x        = px_x_q;
   assign px_y        = px_y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

   typedef struct {
      int hsp; int hbp; int hact; int hfp;
      int vsp; int vbp; int vact; int vfp;
   } geom_t;

   typedef struct packed {
      logic [11:0] h;
      logic [11:0] v;
      logic        hs;
      logic        vs;
      logic        act;
      logic [9:0]  px;
      logic [8:0]  py;
      logic        ls;
      logic        fs;
      logic [15:0] fc;
   } obs_t;

   typedef struct {
      string name;
      int    frame;
      int    v;
      int    h;
      logic  hs;
      logic  vs;
      logic  act;
      int    px;
      int    py;
      logic  ls;
      logic  fs;
   } vec_t;

   // ---------------- clock and DUTs ----------------
   logic clk = 1'b0;
   always #20 clk = ~clk;

   logic rst_a = 1'b0, ena_a = 1'b0;
   logic rst_b = 1'b0, ena_b = 1'b0;

   logic [11:0] h_a, v_a, h_b, v_b;
   logic        hs_a, vs_a, av_a, ls_a, fs_a;
   logic        hs_b, vs_b, av_b, ls_b, fs_b;
   logic [9:0]  px_a, px_b;
   logic [8:0]  py_a, py_b;
   logic [15:0] fc_a, fc_b;

   // Full-size 640x480 instance
   vga_timing_gen dut_a (
      .vga_clk     (clk),
      .rst_n       (rst_a),
      .ena         (ena_a),
      .h_cnt       (h_a),
      .v_cnt       (v_a),
      .hsync       (hs_a),
      .vsync       (vs_a),
      .active      (av_a),
      .px_x        (px_a),
      .px_y        (py_a),
`ifdef VGA_FRAME_CNT_EN
      .frame_cnt   (fc_a),
`endif
      .line_start  (ls_a),
      .frame_start (fs_a)
   );

   // Shrunken geometry so whole frames fit in a short run: 15 x 10
   vga_timing_gen #(
      .H_SYNC_PULSE(3), .H_BACK_PORCH(2), .H_ACTIVE_TIME(8), .H_FRONT_PORCH(2),
      .H_LINE_PERIOD(15),
      .V_SYNC_PULSE(2), .V_BACK_PORCH(2), .V_ACTIVE_TIME(4), .V_FRONT_PORCH(2),
      .V_FRAME_PERIOD(10)
   ) dut_b (
      .vga_clk     (clk),
      .rst_n       (rst_b),
      .ena         (ena_b),
      .h_cnt       (h_b),
      .v_cnt       (v_b),
      .hsync       (hs_b),
      .vsync       (vs_b),
      .active      (av_b),
      .px_x        (px_b),
      .px_y        (py_b),
`ifdef VGA_FRAME_CNT_EN
      .frame_cnt   (fc_b),
`endif
      .line_start  (ls_b),
      .frame_start (fs_b)
   );

`ifndef VGA_FRAME_CNT_EN
   assign fc_a = '0;
   assign fc_b = '0;
`endif

   obs_t o_a, o_b;
   assign o_a = {h_a, v_a, hs_a, vs_a, av_a, px_a, py_a, ls_a, fs_a, fc_a};
   assign o_b = {h_b, v_b, hs_b, vs_b, av_b, px_b, py_b, ls_b, fs_b, fc_b};

   // ---------------- bookkeeping ----------------
   int n_chk  = 0;
   int n_fail = 0;
   bit done   = 1'b0;

   task automatic finish_up();
      if (!done) begin
         done = 1'b1;
         $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      end
      $finish;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
         if (n_fail >= 40) finish_up();
      end
   endtask

   // ---------------- reference model ----------------
   // Position is just the number of enabled cycles since reset; everything
   // else follows from dividing it by the line and frame lengths.
   geom_t  GA, GB;
   longint t_a = 0, t_b = 0;
   bit     adv_a = 1'b0, adv_b = 1'b0;

   function automatic obs_t model(input longint t, input bit adv, input geom_t g);
      obs_t   o;
      int     hp, vp, h, v, hs0, vs0;
      longint fp;
      hp  = g.hsp + g.hbp + g.hact + g.hfp;
      vp  = g.vsp + g.vbp + g.vact + g.vfp;
      fp  = longint'(hp) * vp;
      h   = int'(t % hp);
      v   = int'((t / hp) % vp);
      hs0 = g.hsp + g.hbp;
      vs0 = g.vsp + g.vbp;
      o     = '0;
      o.h   = 12'(h);
      o.v   = 12'(v);
      o.hs  = (h >= g.hsp);
      o.vs  = (v >= g.vsp);
      o.act = (h >= hs0) && (h < hs0 + g.hact) && (v >= vs0) && (v < vs0 + g.vact);
      if (o.act) begin
         o.px = 10'(h - hs0);
         o.py = 9'(v - vs0);
      end
      o.ls = adv && (h == 0);
      o.fs = adv && (h == 0) && (v == 0);
`ifdef VGA_FRAME_CNT_EN
      o.fc = 16'(t / fp);
`endif
      return o;
   endfunction

   function automatic longint pos(input geom_t g, input int frame, input int v, input int h);
      longint hp, vp;
      hp = g.hsp + g.hbp + g.hact + g.hfp;
      vp = g.vsp + g.vbp + g.vact + g.vfp;
      return longint'(frame) * hp * vp + longint'(v) * hp + h;
   endfunction

   function automatic obs_t vec_obs(input vec_t e);
      obs_t o;
      o     = '0;
      o.h   = 12'(e.h);
      o.v   = 12'(e.v);
      o.hs  = e.hs;
      o.vs  = e.vs;
      o.act = e.act;
      o.px  = 10'(e.px);
      o.py  = 9'(e.py);
      o.ls  = e.ls;
      o.fs  = e.fs;
      return o;
   endfunction

   // ---------------- period measurement ----------------
   longint cyc = 0;
   logic   prev_hs_a = 1'b0, prev_vs_b = 1'b0;
   longint last_hs_a = -1, per_hs_a = -1;
   longint last_vs_b = -1, per_vs_b = -1;

   // One clock: advance both models with the inputs seen at the edge, then
   // compare both DUTs against them.
   task automatic step();
      @(posedge clk);
      cyc++;
      if (!rst_a) begin t_a = 0; adv_a = 1'b0; end
      else if (ena_a) begin t_a++; adv_a = 1'b1; end
      else adv_a = 1'b0;
      if (!rst_b) begin t_b = 0; adv_b = 1'b0; end
      else if (ena_b) begin t_b++; adv_b = 1'b1; end
      else adv_b = 1'b0;
      #1;
      chk("cycle_a", o_a, model(t_a, adv_a, GA));
      chk("cycle_b", o_b, model(t_b, adv_b, GB));
      if (prev_hs_a && !hs_a) begin
         if (last_hs_a >= 0) per_hs_a = cyc - last_hs_a;
         last_hs_a = cyc;
      end
      if (prev_vs_b && !vs_b) begin
         if (last_vs_b >= 0) per_vs_b = cyc - last_vs_b;
         last_vs_b = cyc;
      end
      prev_hs_a = hs_a;
      prev_vs_b = vs_b;
   endtask

   task automatic run_a(input longint target);
      int guard = 0;
      while (t_a < target && guard < 60000) begin step(); guard++; end
   endtask

   task automatic run_b(input longint target);
      int guard = 0;
      while (t_b < target && guard < 2000) begin step(); guard++; end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #4000000;
      $display("FAIL watchdog: simulation did not complete in time");
      n_fail++;
      finish_up();
   end

   // ---------------- test sequence ----------------
   vec_t tab_a[10];
   vec_t tab_b[12];

   initial begin
      obs_t a;
      int   ls_count;
      int   n;

      GA = '{96, 48, 640, 16, 2, 33, 480, 10};
      GB = '{3, 2, 8, 2, 2, 2, 4, 2};

      //                name          fr  v    h   hs    vs    act  px   py  ls    fs
      tab_a[0] = '{"a_v1_h799",  0,  1, 799, 1'b1, 1'b0, 1'b0,   0,  0, 1'b0, 1'b0};
      tab_a[1] = '{"a_v2_h0",    0,  2,   0, 1'b0, 1'b1, 1'b0,   0,  0, 1'b1, 1'b0};
      tab_a[2] = '{"a_v2_h95",   0,  2,  95, 1'b0, 1'b1, 1'b0,   0,  0, 1'b0, 1'b0};
      tab_a[3] = '{"a_v2_h96",   0,  2,  96, 1'b1, 1'b1, 1'b0,   0,  0, 1'b0, 1'b0};
      tab_a[4] = '{"a_v35_h143", 0, 35, 143, 1'b1, 1'b1, 1'b0,   0,  0, 1'b0, 1'b0};
      tab_a[5] = '{"a_v35_h144", 0, 35, 144, 1'b1, 1'b1, 1'b1,   0,  0, 1'b0, 1'b0};
      tab_a[6] = '{"a_v35_h783", 0, 35, 783, 1'b1, 1'b1, 1'b1, 639,  0, 1'b0, 1'b0};
      tab_a[7] = '{"a_v35_h784", 0, 35, 784, 1'b1, 1'b1, 1'b0,   0,  0, 1'b0, 1'b0};
      tab_a[8] = '{"a_v36_h144", 0, 36, 144, 1'b1, 1'b1, 1'b1,   0,  1, 1'b0, 1'b0};
      tab_a[9] = '{"a_v36_h500", 0, 36, 500, 1'b1, 1'b1, 1'b1, 356,  1, 1'b0, 1'b0};

      tab_b[0]  = '{"b_v0_h2",   0, 0,  2, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
      tab_b[1]  = '{"b_v0_h3",   0, 0,  3, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
      tab_b[2]  = '{"b_v1_h14",  0, 1, 14, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
      tab_b[3]  = '{"b_v2_h0",   0, 2,  0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0};
      tab_b[4]  = '{"b_v3_h5",   0, 3,  5, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
      tab_b[5]  = '{"b_v4_h4",   0, 4,  4, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
      tab_b[6]  = '{"b_v4_h5",   0, 4,  5, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0};
      tab_b[7]  = '{"b_v4_h12",  0, 4, 12, 1'b1, 1'b1, 1'b1, 7, 0, 1'b0, 1'b0};
      tab_b[8]  = '{"b_v4_h13",  0, 4, 13, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
      tab_b[9]  = '{"b_v7_h12",  0, 7, 12, 1'b1, 1'b1, 1'b1, 7, 3, 1'b0, 1'b0};
      tab_b[10] = '{"b_v8_h5",   0, 8,  5, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0};
      tab_b[11] = '{"b_f1_v0_h0",1, 0,  0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1};

      // Reset held for a few clocks
      repeat (3) step();
      chk("reset_state_a", o_a, 64'h0);
      chk("reset_state_b", o_b, 64'h0);

      // Release with counting enabled; the first edge shows (1,0)
      rst_a = 1'b1; rst_b = 1'b1; ena_a = 1'b1; ena_b = 1'b1;
      step();
      chk("first_after_release_a", {h_a, v_a}, {12'd1, 12'd0});
      ls_count = 0;
      for (int i = 1; i < 800; i++) begin
         step();
         ls_count += int'(ls_a);
      end
      chk("line_wrap_h", 64'(h_a), 64'd0);
      chk("line_wrap_v", 64'(v_a), 64'd1);
      chk("line_start_count", 64'(ls_count), 64'd1);

      // Full-size boundary table
      for (int i = 0; i < 10; i++) begin
         run_a(pos(GA, tab_a[i].frame, tab_a[i].v, tab_a[i].h));
         a = o_a;
         a.fc = '0;
         chk(tab_a[i].name, a, vec_obs(tab_a[i]));
      end
      chk("hsync_period_a", 64'(per_hs_a), 64'd800);
      chk("vsync_period_b", 64'(per_vs_b), 64'd150);

      // Pause at h=500 for 10 cycles
      ena_a = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("pause_hold", {h_a, ls_a, fs_a}, {12'd500, 2'b00});
      end
      ena_a = 1'b1;
      step();
      chk("resume_next", 64'(h_a), 64'd501);

      // Asynchronous reset mid-line takes effect without a clock edge
      repeat (5) step();
      rst_a = 1'b0;
      #1;
      t_a = 0; adv_a = 1'b0;
      chk("async_rst_a", o_a, 64'h0);
      repeat (2) step();
      rst_a = 1'b1;
      step();
      chk("restart_a", {h_a, v_a, ls_a}, {12'd1, 12'd0, 1'b0});

      // Small geometry: reset mid-frame, then walk the corner table to the
      // next frame wrap
      rst_b = 1'b0;
      #1;
      t_b = 0; adv_b = 1'b0;
      chk("async_rst_b", o_b, 64'h0);
      step();
      rst_b = 1'b1;
      for (int i = 0; i < 12; i++) begin
         run_b(pos(GB, tab_b[i].frame, tab_b[i].v, tab_b[i].h));
         a = o_b;
         a.fc = '0;
         chk(tab_b[i].name, a, vec_obs(tab_b[i]));
      end
`ifdef VGA_FRAME_CNT_EN
      chk("frame_cnt_first", 64'(fc_b), 64'd1);
`endif

      // Reset mid-frame; the next frame_start is one full frame later
      repeat (37) step();
      rst_b = 1'b0;
      #1;
      t_b = 0; adv_b = 1'b0;
      chk("async_rst_b2", o_b, 64'h0);
      step();
      rst_b = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!fs_b && n < 1000);
      chk("frame_start_after_rst", 64'(n), 64'd150);

      // Random enables and occasional asynchronous resets
      for (int i = 0; i < 3000; i++) begin
         ena_a = ($urandom_range(0, 3) != 0);
         ena_b = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) begin
            rst_b = 1'b0;
            #1;
            t_b = 0; adv_b = 1'b0;
            chk("rnd_async_rst_b", o_b, 64'h0);
            repeat ($urandom_range(1, 3)) step();
            rst_b = 1'b1;
         end
         step();
      end

      finish_up();
   end

endmodule
